cal_eeprom_router: RTL
======================

Name: cal_eeprom_router

Overview:
- Parametrised successor to the fixed-map EEPROM calibration loader. Sits between the EEPROM reader and the per-pixel calibration RAMs.
- Captures the header bytes into a readable register file. Routes per-pixel calibration regions, defined by a parameter table, to one-hot RAM write ports, assembling 8- or 16-bit words internally.
- Tracks load progress, a 16-bit byte checksum and sequence errors.

Parameters:
ADDR_W, 15, EEPROM byte-address width
HDR_BYTES, 256, header bytes captured into the register file (addresses 0..HDR_BYTES-1)
N_REGION, 6, number of routed regions
REGION_BASE, {0x5800,0x3000,0x1C00,0x1200,0x0800,0x0080}, packed N_REGION*ADDR_W, inclusive base of each region; region 0 is in the LSBs
REGION_LIMIT, {0x8000,0x5800,0x3000,0x1C00,0x1200,0x00B0}, packed N_REGION*(ADDR_W+1), exclusive limit of each region
REGION_WIDE, 6'b110111, per region: 1 = 16-bit little-endian words, 0 = 8-bit
DEFPIX_REGION, 0, index of the dead-pixel region whose word count is limited by the header
DEFPIX_CNT_OFS, 0x7F, header offset holding the dead-pixel count
LAST_ADDR, 0x7FFF, address that completes a load

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load
in_valid  in  1  byte strobe
in_addr  in  ADDR_W  EEPROM byte address
in_data  in  8  EEPROM byte
hdr_rd_addr  in  clog2(HDR_BYTES)  header read address
hdr_rd_data  out  8  header byte (combinational read)
wr_en  out  N_REGION  one-hot region write strobe
wr_addr  out  ADDR_W  word index within the region
wr_data  out  16  word; upper byte is zero for 8-bit regions
busy  out  1  load in progress
done  out  1  load complete, held until next start
err_seq  out  1  sticky: high byte of a 16-bit word arrived without its matching low byte
checksum  out  16  modulo-2^16 sum of accepted bytes
byte_cnt  out  ADDR_W+1  count of accepted bytes

Behaviour:
- Reset values: all outputs 0, header file all 0, state IDLE, low-byte-pending flag clear.
- States:
  - IDLE -> LOAD on start.
  - LOAD -> DONE on an accepted byte with in_addr == LAST_ADDR.
  - DONE -> LOAD on start.
- start in any state, including mid-load:
  - clears checksum, byte_cnt, err_seq, done and the pending flag;
  - sets busy;
  - a byte presented in the same cycle as start is ignored.
- A byte is accepted only when in_valid is high and the state is LOAD. In IDLE or DONE, bytes are dropped and no counters change.
- busy = (state == LOAD). done is registered and rises the cycle after the LAST_ADDR byte is accepted.
- Header capture: an accepted byte with in_addr < HDR_BYTES is written to hdr[in_addr]. Header capture and region routing are independent; a byte may do both.
- Region match: region i matches when REGION_BASE[i] <= in_addr < REGION_LIMIT[i]. On overlap the lowest index wins. A byte that matches no region is not routed, but is still checksummed.
- Word offset: off = in_addr - REGION_BASE[i].
- 8-bit region: write with wr_addr = off, wr_data = {8'h00, in_data}.
- 16-bit region, even off: store the low byte and the address, set pending; no write.
- 16-bit region, odd off:
  - if pending is set and the stored address equals in_addr-1: write with wr_addr = off>>1, wr_data = {in_data, low}, then clear pending;
  - otherwise set err_seq, do not write, clear pending.
- An even byte arriving while pending is set overwrites the pending low byte silently.
- Dead-pixel limit: in DEFPIX_REGION, a write whose wr_addr >= hdr[DEFPIX_CNT_OFS] is suppressed. The count used is the value in the header file at the time of the write.
- Latency: wr_en, wr_addr and wr_data are registered, one cycle after the accepted byte. wr_en is high for exactly one cycle per write, at most one bit set.
- checksum and byte_cnt update in the cycle after acceptance. Both wrap modulo their width.
- Reset mid-load returns to the reset state immediately; partial words are discarded.

Test Plan:
- Reset -> all outputs 0, hdr_rd_data = 0 for every address; start -> busy = 1 next cycle.
- Load bytes 0x00..0xFF with data = address[7:0] -> hdr[0x42] reads 0x42; checksum = 0x7F80; byte_cnt = 256; no wr_en except region 0.
- hdr[0x7F] = 2, then bytes at 0x80..0x85 = 11,22,33,44,55,66 -> writes to region 0 at addr 0 (0x2211) and addr 1 (0x4433); the third word (0x6655) is suppressed.
- Byte 0x1C05 = 0xAB -> wr_en = 6'b001000, wr_addr = 5, wr_data = 0x00AB, one cycle after acceptance.
- Byte at 0x3001 sent with no preceding 0x3000 -> err_seq = 1 (sticky); no write. Then 0x3002 = 0x10 and 0x3003 = 0x20 -> region 4 write at addr 1, data 0x2010.
- Accept the byte at 0x7FFF -> done = 1, busy = 0; later bytes are ignored. start asserted mid-load -> counters clear, done = 0, pending word discarded.

Source files
------------

// File: rtl/cal_eeprom_router.sv
`default_nettype none
// ============================================================================
// Module   : cal_eeprom_router
// Purpose  : Captures EEPROM header bytes and routes calibration regions to
//            one-hot RAM write ports with checksum and progress tracking.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module cal_eeprom_router #(
    parameter int                              ADDR_W         = 15,
    parameter int                              HDR_BYTES      = 256,
    parameter int                              N_REGION       = 6,
    parameter logic [N_REGION*ADDR_W-1:0]      REGION_BASE    = {15'h5800, 15'h3000, 15'h1C00,
                                                                 15'h1200, 15'h0800, 15'h0080},
    parameter logic [N_REGION*(ADDR_W+1)-1:0]  REGION_LIMIT   = {16'h8000, 16'h5800, 16'h3000,
                                                                 16'h1C00, 16'h1200, 16'h00B0},
    parameter logic [N_REGION-1:0]             REGION_WIDE    = 6'b110111,
    parameter int                              DEFPIX_REGION  = 0,
    parameter int                              DEFPIX_CNT_OFS = 'h7F,
    parameter logic [ADDR_W-1:0]               LAST_ADDR      = 15'h7FFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [7:0]                    in_data,
    input  logic [$clog2(HDR_BYTES)-1:0]  hdr_rd_addr,
    output logic [7:0]                    hdr_rd_data,
    output logic [N_REGION-1:0]           wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [15:0]                   wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err_seq,
    output logic [15:0]                   checksum,
    output logic [ADDR_W:0]               byte_cnt
);

    localparam int                c_HA_W    = $clog2(HDR_BYTES);
    localparam logic [ADDR_W:0]   c_HDR_LIM = (ADDR_W+1)'(HDR_BYTES);
    localparam logic [c_HA_W-1:0] c_CNT_IDX = c_HA_W'(DEFPIX_CNT_OFS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_hdr [HDR_BYTES];
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [7:0]          r_pend_low;
    logic [N_REGION-1:0] r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err_seq;
    logic [15:0]         r_checksum;
    logic [ADDR_W:0]     r_byte_cnt;

    logic                w_acc;
    logic                w_hit;
    logic                w_wide;
    logic                w_is_def;
    logic                w_limited;
    logic                w_hdr_hit;
    logic                w_pair_ok;
    logic [N_REGION-1:0] w_sel;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_word;

    // A byte coinciding with start belongs to no load and is dropped.
    assign w_acc = in_valid && (r_state == S_LOAD) && !start;

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        w_hit    = 1'b0;
        w_sel    = '0;
        w_base   = '0;
        w_wide   = 1'b0;
        w_is_def = 1'b0;
        for (int i = N_REGION - 1; i >= 0; i--) begin
            if ((in_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                ({1'b0, in_addr} < REGION_LIMIT[i*(ADDR_W+1) +: ADDR_W+1])) begin
                w_hit    = 1'b1;
                w_sel    = '0;
                w_sel[i] = 1'b1;
                w_base   = REGION_BASE[i*ADDR_W +: ADDR_W];
                w_wide   = REGION_WIDE[i];
                w_is_def = (i == DEFPIX_REGION);
            end
        end
    end

    assign w_off     = in_addr - w_base;
    assign w_word    = w_wide ? (w_off >> 1) : w_off;
    assign w_limited = w_is_def && (w_word >= ADDR_W'(r_hdr[c_CNT_IDX]));
    assign w_hdr_hit = ({1'b0, in_addr} < c_HDR_LIM);
    assign w_pair_ok = r_pend && (r_pend_addr == (in_addr - ADDR_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                r_hdr[i] <= 8'h00;
            end
        end else if (w_acc && w_hdr_hit) begin
            r_hdr[in_addr[c_HA_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_low  <= 8'h00;
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= 16'h0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_seq   <= 1'b0;
            r_checksum  <= 16'h0000;
            r_byte_cnt  <= '0;
        end else begin
            r_wr_en <= '0;
            if (start) begin
                r_state    <= S_LOAD;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_err_seq  <= 1'b0;
                r_pend     <= 1'b0;
                r_checksum <= 16'h0000;
                r_byte_cnt <= '0;
            end else if (w_acc) begin
                r_checksum <= r_checksum + {8'h00, in_data};
                r_byte_cnt <= r_byte_cnt + (ADDR_W+1)'(1);
                if (in_addr == LAST_ADDR) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                if (w_hit) begin
                    if (!w_wide) begin
                        if (!w_limited) begin
                            r_wr_en   <= w_sel;
                            r_wr_addr <= w_word;
                            r_wr_data <= {8'h00, in_data};
                        end
                    end else if (!w_off[0]) begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= in_addr;
                        r_pend_low  <= in_data;
                    end else begin
                        r_pend <= 1'b0;
                        if (!w_pair_ok) begin
                            r_err_seq <= 1'b1;
                        end else if (!w_limited) begin
                            r_wr_en   <= w_sel;
                            r_wr_addr <= w_word;
                            r_wr_data <= {in_data, r_pend_low};
                        end
                    end
                end
            end
        end
    end

    assign hdr_rd_data = r_hdr[hdr_rd_addr];
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_seq     = r_err_seq;
    assign checksum    = r_checksum;
    assign byte_cnt    = r_byte_cnt;

endmodule
`default_nettype wire
